// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; busy_o stalls the pipeline while in flight.
package RS5_pkg;

    typedef enum logic [56:0] {
        NOP, LUI, ADD, SUB, SLTU, SLT, XOR, SRL, SRA, SLL, OR, AND,
        BEQ, BNE, BLT, BLTU, BGE, BGEU, JAL, JALR,
        LB, LBU, LH, LHU, LW, SB, SH, SW,
        MUL, MULH, MULHU, MULHSU,
        DIV, DIVU, REM, REMU
    } iType_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_INIT,
        D_CALC,
        D_SIGN
    } div_states_e;

endpackage

module iterative_divider
    import RS5_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic [56:0] operation_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    div_states_e r_state;

    // r_a holds the dividend, then shifts into the quotient
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_signed;
    logic        r_rem_op;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_special;
    logic [31:0] r_sp_q;
    logic [31:0] r_sp_r;

    logic        w_op_ok;
    logic        w_op_signed;
    logic        w_op_rem;
    logic        w_accept;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic        w_div0;
    logic        w_ovf;

    logic [32:0] w_pr;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;

    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_q_sel;
    logic [31:0] w_r_sel;
    logic [31:0] w_result;

    assign busy_o = (r_state != D_IDLE);

    // Decode which operations this unit owns
    always_comb begin
        w_op_ok     = 1'b0;
        w_op_signed = 1'b0;
        w_op_rem    = 1'b0;
        unique case (operation_i)
            DIV: begin
                w_op_ok     = 1'b1;
                w_op_signed = 1'b1;
            end
            DIVU: begin
                w_op_ok     = 1'b1;
            end
            REM: begin
                w_op_ok     = 1'b1;
                w_op_signed = 1'b1;
                w_op_rem    = 1'b1;
            end
            REMU: begin
                w_op_ok     = 1'b1;
                w_op_rem    = 1'b1;
            end
            default: begin
                w_op_ok     = 1'b0;
            end
        endcase
    end

    assign w_accept = (r_state == D_IDLE) && start_i
                      && w_op_ok && !flush_i;

    // Operand conditioning and special-case detection for D_INIT
    always_comb begin
        w_a_neg = r_signed & r_a[31];
        w_b_neg = r_signed & r_b[31];
        w_a_abs = w_a_neg ? (32'd0 - r_a) : r_a;
        w_b_abs = w_b_neg ? (32'd0 - r_b) : r_b;
        w_div0  = (r_b == 32'd0);
        w_ovf   = r_signed
                  && (r_a == 32'h8000_0000)
                  && (r_b == 32'hFFFF_FFFF);
    end

    // One restoring step: 33-bit shifted remainder minus divisor
    always_comb begin
        w_pr       = {r_rem, r_a[31]};
        w_diff     = w_pr - {1'b0, r_b};
        w_ge       = ~w_diff[32];
        w_rem_next = w_ge ? w_diff[31:0] : w_pr[31:0];
    end

    // Sign fix-up, special-case override and result select
    always_comb begin
        w_q_fix  = r_neg_q ? (32'd0 - r_a) : r_a;
        w_r_fix  = r_neg_r ? (32'd0 - r_rem) : r_rem;
        w_q_sel  = r_special ? r_sp_q : w_q_fix;
        w_r_sel  = r_special ? r_sp_r : w_r_fix;
        w_result = r_rem_op ? w_r_sel : w_q_sel;
    end

    // Divider FSM with registered result and valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= D_IDLE;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rem     <= 32'd0;
            r_cnt     <= 5'd0;
            r_signed  <= 1'b0;
            r_rem_op  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_sp_q    <= 32'd0;
            r_sp_r    <= 32'd0;
            valid_o   <= 1'b0;
            result_o  <= 32'd0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i && (r_state != D_IDLE)) begin
                r_state <= D_IDLE;
            end else begin
                unique case (r_state)
                    D_IDLE: begin
                        if (w_accept) begin
                            r_a      <= rs1_data_i;
                            r_b      <= rs2_data_i;
                            r_signed <= w_op_signed;
                            r_rem_op <= w_op_rem;
                            r_state  <= D_INIT;
                        end
                    end
                    D_INIT: begin
                        r_a       <= w_a_abs;
                        r_b       <= w_b_abs;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_rem     <= 32'd0;
                        r_cnt     <= 5'd0;
                        r_special <= w_div0 | w_ovf;
                        r_sp_q    <= w_div0 ? 32'hFFFF_FFFF
                                            : 32'h8000_0000;
                        r_sp_r    <= w_div0 ? r_a : 32'd0;
                        if (EARLY_EXIT && (w_div0 || w_ovf))
                            r_state <= D_SIGN;
                        else
                            r_state <= D_CALC;
                    end
                    D_CALC: begin
                        r_a   <= {r_a[30:0], w_ge};
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31)
                            r_state <= D_SIGN;
                    end
                    D_SIGN: begin
                        result_o <= w_result;
                        valid_o  <= 1'b1;
                        r_state  <= D_IDLE;
                    end
                    default: begin
                        r_state <= D_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider: vector table, random ops, scoreboard,
// plus hand-written flush/reset/busy/back-to-back/no-early-exit cases.
module tb_iterative_divider;
    import RS5_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start;
    logic        start0;
    logic [56:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        busy0;
    logic        valid0;
    logic [31:0] result0;

    int n_chk;
    int n_fail;
    int cyc;
    int last_t0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    typedef struct {
        logic [56:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[16];

    iterative_divider #(.EARLY_EXIT(1'b1)) dut (
        .clk(clk),
        .reset_n(rst_n),
        .flush_i(flush),
        .start_i(start),
        .operation_i(op),
        .rs1_data_i(a),
        .rs2_data_i(b),
        .busy_o(busy),
        .valid_o(valid),
        .result_o(result)
    );

    iterative_divider #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk),
        .reset_n(rst_n),
        .flush_i(flush),
        .start_i(start0),
        .operation_i(op),
        .rs1_data_i(a),
        .rs2_data_i(b),
        .busy_o(busy0),
        .valid_o(valid0),
        .result_o(result0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every valid_o must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL stray_valid: got result %h expected no valid",
                         result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("latency", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    function automatic logic [31:0] model(input logic [56:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (o == DIV)  return 32'(sx / sy);
        if (o == REM)  return 32'(sx % sy);
        if (o == DIVU) return x / y;
        return x % y;
    endfunction

    // Called just after a negedge; returns at the negedge of cycle 1
    task automatic drive(input logic [56:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit push,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        op      = o;
        a       = x;
        b       = y;
        start   = 1'b1;
        last_t0 = cyc;
        if (push) begin
            e.res = exp;
            e.due = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = ADD;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic ee0(input logic [56:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
        int t0;
        int k;
        op     = o;
        a      = x;
        b      = y;
        start0 = 1'b1;
        t0     = cyc;
        @(negedge clk);
        start0 = 1'b0;
        a      = $urandom;
        b      = $urandom;
        k      = 0;
        while (!valid0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("ee0_latency", 32'(cyc - t0), 32'd35);
        chk("ee0_result", result0, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [56:0] ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        tbl[0]  = '{DIVU, 32'd100, 32'd7, 32'd14, 35};
        tbl[1]  = '{REMU, 32'd100, 32'd7, 32'd2, 35};
        tbl[2]  = '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35};
        tbl[3]  = '{REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35};
        tbl[4]  = '{REM, 32'd7, 32'hFFFFFFFE, 32'd1, 35};
        tbl[5]  = '{DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 3};
        tbl[6]  = '{REMU, 32'd5, 32'd0, 32'd5, 3};
        tbl[7]  = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3};
        tbl[8]  = '{REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 3};
        tbl[9]  = '{DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 3};
        tbl[10] = '{REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 3};
        tbl[11] = '{DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 35};
        tbl[12] = '{DIV, 32'h80000000, 32'd1, 32'h80000000, 35};
        tbl[13] = '{DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 35};
        tbl[14] = '{DIV, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'd6, 35};
        tbl[15] = '{REM, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'hFFFFFFFE, 35};

        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        op     = ADD;
        a      = 32'd0;
        b      = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // busy profile of a full-length operation
        drive(DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 35);
        for (int k = 1; k <= 35; k++) begin
            chk("busy_profile", 32'(busy), 32'(k <= 34));
            if (k < 35) @(negedge clk);
        end
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1,
                  tbl[i].res, tbl[i].lat);
            wait_idle();
        end

        for (int i = 0; i < 8; i++) begin
            sel = $urandom_range(0, 3);
            ro  = (sel == 0) ? DIV : (sel == 1) ? DIVU
                : (sel == 2) ? REM : REMU;
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd3;
            drive(ro, ra, rb, 1'b1, model(ro, ra, rb), 35);
            wait_idle();
        end

        // non-divider op is ignored
        drive(ADD, 32'd10, 32'd2, 1'b0, 32'd0, 0);
        chk("ignore_add_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // start while busy is ignored
        drive(DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 35);
        repeat (3) @(negedge clk);
        op    = DIVU;
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // flush in cycle 10, new op in cycle 11
        drive(DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_result_hold", result, 32'd14);
        drive(DIVU, 32'd9, 32'd3, 1'b1, 32'd3, 35);
        chk("flush_total_due", 32'(sb[0].due - last_t0 + 11), 32'd46);
        wait_idle();

        // back-to-back issue in the valid cycle
        drive(DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 35);
        repeat (34) @(negedge clk);
        drive(DIVU, 32'd200, 32'd9, 1'b1, 32'd22, 35);
        wait_idle();

        // asynchronous reset mid-operation
        drive(DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 0);
        repeat (19) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_valid", 32'(valid), 32'd0);
        chk("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // no early exit: special cases take the full path
        ee0(DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
        ee0(REMU, 32'd5, 32'd0, 32'd5);
        ee0(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        ee0(REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
